// File: rtl/inst_fetch_if.sv
// Fetch-stage bundle: redirect/stall controls in, instruction SRAM port and IF->ID bus out.
// Ports: flush/new_pc, stall vector, br_bus {valid,target}, stallreq_for_fifo (into fetch);
//        inst_sram_{en,wen,addr,wdata} and if_to_id_bus {discard,ce,pc} (out of fetch).
interface inst_fetch_if #(
  parameter int STALL_WD    = 6,
  parameter int IF_TO_ID_WD = 34
);
  logic                   flush;
  logic [31:0]            new_pc;
  logic [STALL_WD-1:0]    stall;
  logic [32:0]            br_bus;
  logic                   stallreq_for_fifo;

  logic                   inst_sram_en;
  logic [7:0]             inst_sram_wen;
  logic [31:0]            inst_sram_addr;
  logic [63:0]            inst_sram_wdata;
  logic [IF_TO_ID_WD-1:0] if_to_id_bus;

  // master: the fetch stage itself
  modport master (
    input  flush, new_pc, stall, br_bus, stallreq_for_fifo,
    output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata, if_to_id_bus
  );

  // slave: the surrounding pipeline / SRAM that consumes fetches and issues redirects
  modport slave (
    output flush, new_pc, stall, br_bus, stallreq_for_fifo,
    input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata, if_to_id_bus
  );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch PC generator: issues one 64-bit (two-instruction) SRAM read per cycle.
// Latency: redirect seen in cycle N drives inst_sram_addr in cycle N+1; SRAM data returns one cycle after the address.
// Backpressure: stall[0] or stallreq_for_fifo suppress inst_sram_en and freeze the PC; redirects are still accepted.
// Ports: clk, rst (sync, active-high); ifb (inst_fetch_if.master) carries redirects, stalls, SRAM port and IF->ID bus.
module inst_fetch #(
  parameter logic [31:0] RESET_PC   = 32'hBFC00000,
  parameter logic [31:0] FETCH_STEP = 32'd8
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master ifb
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc_r, pc_n;
  logic        ce_r, ce_n;
  logic        pend_v, pend_v_n;
  logic [31:0] pend_pc, pend_pc_n;

  logic        hold_fetch;
  logic        br_v;
  logic [31:0] br_target;
  logic        fetch_en;
  logic        discard;

  assign hold_fetch = ifb.stall[0] | ifb.stallreq_for_fifo;
  assign br_v       = ifb.br_bus[32];
  assign br_target  = ifb.br_bus[31:0];

  // Only the PC-stage bit of the stall vector matters here; the IF/ID bit is
  // handled by the register that consumes if_to_id_bus.
  logic unused_stall_bits;
  assign unused_stall_bits = ^ifb.stall[$bits(ifb.stall)-1:1];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= BOOT;
      pc_r    <= 32'h0;
      ce_r    <= 1'b0;
      pend_v  <= 1'b0;
      pend_pc <= 32'h0;
    end else begin
      state   <= state_n;
      pc_r    <= pc_n;
      ce_r    <= ce_n;
      pend_v  <= pend_v_n;
      pend_pc <= pend_pc_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / next-PC
  // ---------------------------------------------------------------------------
  always_comb begin
    state_n   = state;
    pc_n      = pc_r;
    ce_n      = ce_r;
    pend_v_n  = pend_v;
    pend_pc_n = pend_pc;

    unique case (state)
      BOOT: begin
        pc_n    = RESET_PC;
        ce_n    = 1'b1;
        state_n = RUN;
      end

      RUN, HOLD: begin
        if (!hold_fetch) begin
          state_n = RUN;
          if (br_v) begin
            // A live redirect is younger than anything parked, so it wins.
            pc_n     = br_target;
            pend_v_n = 1'b0;
          end else if (pend_v) begin
            pc_n     = pend_pc;
            pend_v_n = 1'b0;
          end else begin
            pc_n = pc_r + FETCH_STEP;
          end
        end else begin
          state_n = HOLD;
          if (br_v) begin
            if (ifb.stall[0]) begin
              // Pipeline stall: PC must stay put, park the target until release.
              pend_pc_n = br_target;
              pend_v_n  = 1'b1;
            end else begin
              // Buffer-full only: the decode buffer keeps slack for this, so
              // the redirect lands in pc_r now and waits there for the release.
              pc_n     = br_target;
              pend_v_n = 1'b0;
            end
          end
        end
      end

      default: begin
        state_n = BOOT;
        ce_n    = 1'b0;
        pend_v_n = 1'b0;
      end
    endcase

    // Exception/ERET redirect overrides stalls, branches and anything pending.
    if (ifb.flush) begin
      pc_n     = ifb.new_pc;
      ce_n     = 1'b1;
      pend_v_n = 1'b0;
      state_n  = RUN;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (gated by rst so nothing leaks out during the reset cycle itself)
  // ---------------------------------------------------------------------------
  assign fetch_en = ce_r & ~hold_fetch & ~rst;

  // The fetch issued alongside a redirect is on the wrong path.
  assign discard  = ~rst & (ifb.flush | (br_v & ce_r));

  assign ifb.inst_sram_en    = fetch_en;
  assign ifb.inst_sram_wen   = 8'h00;
  assign ifb.inst_sram_addr  = pc_r;
  assign ifb.inst_sram_wdata = 64'h0;
  assign ifb.if_to_id_bus    = rst ? 34'b0 : {discard, fetch_en, pc_r};

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: table of per-cycle vectors plus hand sequences,
// with expected outputs queued at drive time and compared mid-cycle by a monitor.
module tb_inst_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  inst_fetch_if bus_if ();

  inst_fetch dut (
    .clk (clk),
    .rst (rst),
    .ifb (bus_if.master)
  );

  typedef struct {
    logic        rst;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall0;
    logic        fifo;
    logic        brv;
    logic [31:0] brt;
    logic        en;
    logic [31:0] addr;
    logic        disc;
  } vec_t;

  typedef struct {
    logic        en;
    logic [31:0] addr;
    logic [33:0] bus;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic r, input logic fl, input logic [31:0] npc,
                              input logic s0, input logic ff, input logic bv,
                              input logic [31:0] bt, input logic en, input logic [31:0] addr,
                              input logic disc);
    vec_t v;
    v.rst = r; v.flush = fl; v.new_pc = npc; v.stall0 = s0; v.fifo = ff;
    v.brv = bv; v.brt = bt; v.en = en; v.addr = addr; v.disc = disc;
    return v;
  endfunction

  // Drive one cycle of inputs, queue what the DUT must show during that cycle.
  task automatic step(input vec_t v);
    exp_t e;
    rst                      = v.rst;
    bus_if.flush             = v.flush;
    bus_if.new_pc            = v.new_pc;
    bus_if.stall             = {5'b0, v.stall0};
    bus_if.stallreq_for_fifo = v.fifo;
    bus_if.br_bus            = {v.brv, v.brt};
    e.en   = v.en;
    e.addr = v.addr;
    e.bus  = v.rst ? 34'b0 : {v.disc, v.en, v.addr};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("inst_sram_en",    64'(bus_if.inst_sram_en),    64'(e.en));
      chk("inst_sram_addr",  64'(bus_if.inst_sram_addr),  64'(e.addr));
      chk("if_to_id_bus",    64'(bus_if.if_to_id_bus),    64'(e.bus));
      chk("inst_sram_wen",   64'(bus_if.inst_sram_wen),   64'h0);
      chk("inst_sram_wdata", bus_if.inst_sram_wdata,      64'h0);
    end
  end

  localparam logic [31:0] Z = 32'h0;

  initial begin
    vec_t tbl[25];

    bus_if.flush             = 1'b0;
    bus_if.new_pc            = 32'h0;
    bus_if.stall             = '0;
    bus_if.stallreq_for_fifo = 1'b0;
    bus_if.br_bus            = '0;
    rst                      = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    //             rst fl  new_pc        s0 ff bv target        en addr          disc
    tbl[0]  = mk(1, 0, Z,            0, 0, 0, Z,            0, 32'h00000000, 0); // reset state
    tbl[1]  = mk(0, 0, Z,            0, 0, 0, Z,            0, 32'h00000000, 0); // BOOT
    tbl[2]  = mk(0, 0, Z,            0, 0, 0, Z,            1, 32'hBFC00000, 0);
    tbl[3]  = mk(0, 0, Z,            0, 0, 0, Z,            1, 32'hBFC00008, 0);
    tbl[4]  = mk(0, 0, Z,            0, 0, 1, 32'hBFC00104, 1, 32'hBFC00010, 1); // branch
    tbl[5]  = mk(0, 0, Z,            0, 0, 0, Z,            1, 32'hBFC00104, 0);
    tbl[6]  = mk(0, 0, Z,            0, 0, 0, Z,            1, 32'hBFC0010C, 0);
    tbl[7]  = mk(0, 0, Z,            1, 0, 1, 32'h80000020, 0, 32'hBFC00114, 1); // stalled branch
    tbl[8]  = mk(0, 0, Z,            1, 0, 0, Z,            0, 32'hBFC00114, 0);
    tbl[9]  = mk(0, 0, Z,            1, 0, 0, Z,            0, 32'hBFC00114, 0);
    tbl[10] = mk(0, 0, Z,            0, 0, 0, Z,            1, 32'hBFC00114, 0); // release
    tbl[11] = mk(0, 0, Z,            0, 0, 0, Z,            1, 32'h80000020, 0); // pending target
    tbl[12] = mk(0, 1, 32'hBFC00380, 1, 0, 1, 32'h00001234, 0, 32'h80000028, 1); // flush wins
    tbl[13] = mk(0, 0, Z,            1, 0, 0, Z,            0, 32'hBFC00380, 0);
    tbl[14] = mk(0, 0, Z,            0, 0, 0, Z,            1, 32'hBFC00380, 0);
    tbl[15] = mk(0, 0, Z,            0, 0, 0, Z,            1, 32'hBFC00388, 0); // no stale pend
    tbl[16] = mk(0, 0, Z,            0, 1, 1, 32'h00001000, 0, 32'hBFC00390, 1); // fifo-full branch
    tbl[17] = mk(0, 0, Z,            0, 1, 0, Z,            0, 32'h00001000, 0);
    tbl[18] = mk(0, 0, Z,            0, 1, 0, Z,            0, 32'h00001000, 0);
    tbl[19] = mk(0, 0, Z,            0, 0, 0, Z,            1, 32'h00001000, 0);
    tbl[20] = mk(0, 0, Z,            0, 0, 0, Z,            1, 32'h00001008, 0);
    tbl[21] = mk(0, 0, Z,            1, 0, 1, 32'h00002000, 0, 32'h00001010, 1); // pend 2000
    tbl[22] = mk(0, 0, Z,            1, 0, 1, 32'h00003000, 0, 32'h00001010, 1); // overwrite
    tbl[23] = mk(0, 0, Z,            0, 0, 0, Z,            1, 32'h00001010, 0);
    tbl[24] = mk(0, 0, Z,            0, 0, 0, Z,            1, 32'h00003000, 0);

    for (int i = 0; i < 25; i++) step(tbl[i]);

    // PC wraps from the top of the address space to zero.
    step(mk(0, 1, 32'hFFFFFFF0, 0, 0, 0, Z, 1, 32'h00003008, 1));
    step(mk(0, 0, Z,            0, 0, 0, Z, 1, 32'hFFFFFFF0, 0));
    step(mk(0, 0, Z,            0, 0, 0, Z, 1, 32'hFFFFFFF8, 0));
    step(mk(0, 0, Z,            0, 0, 0, Z, 1, 32'h00000000, 0));
    step(mk(0, 0, Z,            0, 0, 0, Z, 1, 32'h00000008, 0));

    // Reset in the middle of a hold with a parked redirect: all of it is dropped.
    step(mk(0, 0, Z,            1, 0, 1, 32'h00004000, 0, 32'h00000010, 1));
    step(mk(0, 0, Z,            1, 0, 0, Z,            0, 32'h00000010, 0));
    step(mk(1, 0, Z,            1, 0, 0, Z,            0, 32'h00000010, 0));
    step(mk(1, 0, Z,            0, 0, 0, Z,            0, 32'h00000000, 0));
    step(mk(0, 0, Z,            0, 0, 0, Z,            0, 32'h00000000, 0));
    step(mk(0, 0, Z,            0, 0, 0, Z,            1, 32'hBFC00000, 0));

    // Unaligned target bits pass straight through.
    step(mk(0, 0, Z,            0, 0, 1, 32'h00000103, 1, 32'hBFC00008, 1));
    step(mk(0, 0, Z,            0, 0, 0, Z,            1, 32'h00000103, 0));
    step(mk(0, 0, Z,            0, 0, 0, Z,            1, 32'h0000010B, 0));

    // Drain: the monitor should have consumed every queued expectation.
    for (int k = 0; k < 4 && sb_q.size() != 0; k++) @(posedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
